// File: rtl/pipelinedec_ss.sv
// Superscalar decode stage: decodes a LANES-wide bundle and splits it at the first
// intra-bundle RAW hazard, issuing the remaining lanes on later cycles.
module pipelinedec_ss #(
  parameter int unsigned LANES = 2,
  parameter int unsigned CW    = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  instr_valid,
  input  logic [32*LANES-1:0]   instr_d,
  input  logic                  stall_e,
  input  logic                  flush,
  output logic                  ready_d,
  output logic [LANES-1:0]      valid_e,
  output logic [CW*LANES-1:0]   ctrl_e,
  output logic [5*LANES-1:0]    rs_e,
  output logic [5*LANES-1:0]    rt_e,
  output logic [5*LANES-1:0]    rd_e,
  output logic [16*LANES-1:0]   imm_e,
  output logic [LANES-1:0]      illegal_e
);

  localparam int unsigned PW = $clog2(LANES + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SPLIT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [LANES-1:0]    valid_q, valid_d;
  logic [CW*LANES-1:0] ctrl_q, ctrl_d;
  logic [5*LANES-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [16*LANES-1:0] imm_q, imm_d;
  logic [LANES-1:0]    ill_q, ill_d;

  logic [CW-1:0] ctrl_f [LANES];
  logic          ill_f  [LANES];
  logic [4:0]    rs_f   [LANES];
  logic [4:0]    rt_f   [LANES];
  logic [4:0]    rd_f   [LANES];
  logic [4:0]    dest_f [LANES];
  logic          rdrt_f [LANES];
  logic [15:0]   imm_f  [LANES];
  logic [PW-1:0] k_c;
  logic          dep_c;

  // Per-lane opcode decode; dest is zero when the lane writes nothing.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rs_f[l]   = instr_d[32*l+21 +: 5];
      rt_f[l]   = instr_d[32*l+16 +: 5];
      rd_f[l]   = instr_d[32*l+11 +: 5];
      imm_f[l]  = instr_d[32*l +: 16];
      ctrl_f[l] = '0;
      ill_f[l]  = 1'b0;
      rdrt_f[l] = 1'b0;
      case (instr_d[32*l+26 +: 6])
        6'b100011: ctrl_f[l] = CW'(12'b1_1_0_0000_1_0_0_0_0);
        6'b101011: begin ctrl_f[l] = CW'(12'b0_0_1_0000_1_0_0_0_0); rdrt_f[l] = 1'b1; end
        6'b000000: begin ctrl_f[l] = CW'(12'b1_0_0_0010_0_1_0_0_0); rdrt_f[l] = 1'b1; end
        6'b000100: begin ctrl_f[l] = CW'(12'b0_0_0_0001_0_0_1_0_0); rdrt_f[l] = 1'b1; end
        6'b000101: begin ctrl_f[l] = CW'(12'b0_0_0_0001_0_0_0_1_0); rdrt_f[l] = 1'b1; end
        6'b001000: ctrl_f[l] = CW'(12'b1_0_0_0000_1_0_0_0_0);
        6'b001001: ctrl_f[l] = CW'(12'b1_0_0_0111_1_0_0_0_0);
        6'b001100: ctrl_f[l] = CW'(12'b1_0_0_0100_1_0_0_0_0);
        6'b001101: ctrl_f[l] = CW'(12'b1_0_0_0011_1_0_0_0_0);
        6'b001110: ctrl_f[l] = CW'(12'b1_0_0_0101_1_0_0_0_0);
        6'b001010: ctrl_f[l] = CW'(12'b1_0_0_0110_1_0_0_0_0);
        6'b001011: ctrl_f[l] = CW'(12'b1_0_0_1000_1_0_0_0_0);
        6'b000010: ctrl_f[l] = CW'(12'b0_0_0_0000_0_0_0_0_1);
        default:   ill_f[l]  = 1'b1;
      endcase
      dest_f[l] = ctrl_f[l][11] ? (ctrl_f[l][3] ? rd_f[l] : rt_f[l]) : 5'd0;
    end
  end

  // Group end k: lowest lane above ptr that reads a register written by an unissued lane before it.
  always_comb begin
    k_c   = PW'(LANES);
    dep_c = 1'b0;
    for (int j = LANES - 1; j >= 1; j--) begin
      dep_c = 1'b0;
      for (int i = 0; i < j; i++) begin
        if ((PW'(i) >= ptr_q) && (dest_f[i] != 5'd0) &&
            ((dest_f[i] == rs_f[j]) || (rdrt_f[j] && (dest_f[i] == rt_f[j]))))
          dep_c = 1'b1;
      end
      if ((PW'(j) > ptr_q) && dep_c) k_c = PW'(j);
    end
  end

  assign ready_d = resetn & instr_valid & ~stall_e & ~flush & (k_c == PW'(LANES));

  // Next state and next issue registers; flush beats stall, stall holds everything.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    ill_d   = ill_q;
    if (flush || (!stall_e && !instr_valid)) begin
      valid_d = '0;
      ctrl_d  = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      imm_d   = '0;
      ill_d   = '0;
      if (flush) begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    end else if (!stall_e) begin
      for (int l = 0; l < LANES; l++) begin
        valid_d[l]          = (PW'(l) >= ptr_q) && (PW'(l) < k_c);
        ctrl_d[CW*l +: CW]  = valid_d[l] ? ctrl_f[l] : '0;
        rs_d[5*l +: 5]      = valid_d[l] ? rs_f[l]   : 5'd0;
        rt_d[5*l +: 5]      = valid_d[l] ? rt_f[l]   : 5'd0;
        rd_d[5*l +: 5]      = valid_d[l] ? rd_f[l]   : 5'd0;
        imm_d[16*l +: 16]   = valid_d[l] ? imm_f[l]  : 16'd0;
        ill_d[l]            = valid_d[l] & ill_f[l];
      end
      if (k_c == PW'(LANES)) begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end else begin
        state_d = S_SPLIT;
        ptr_d   = k_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      valid_q <= '0;
      ctrl_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      ill_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      ill_q   <= ill_d;
    end
  end

  assign valid_e   = valid_q;
  assign ctrl_e    = ctrl_q;
  assign rs_e      = rs_q;
  assign rt_e      = rt_q;
  assign rd_e      = rd_q;
  assign imm_e     = imm_q;
  assign illegal_e = ill_q;

endmodule

// File: tb/tb_pipelinedec_ss.sv
// Scoreboard bench for pipelinedec_ss (LANES=2): directed bundles push expected issue
// records; a negedge monitor pops one record per non-empty issue and compares.
module tb_pipelinedec_ss;

  logic        clk = 1'b0;
  logic        resetn, instr_valid, stall_e, flush, ready_d;
  logic [63:0] instr_d;
  logic [1:0]  valid_e, illegal_e;
  logic [23:0] ctrl_e;
  logic [9:0]  rs_e, rt_e, rd_e;
  logic [31:0] imm_e;

  typedef struct packed {
    logic [1:0]  v;
    logic [23:0] c;
    logic [9:0]  rs;
    logic [9:0]  rt;
    logic [9:0]  rd;
    logic [31:0] imm;
    logic [1:0]  ill;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipelinedec_ss #(.LANES(2), .CW(12)) dut (
    .clk(clk), .resetn(resetn), .instr_valid(instr_valid), .instr_d(instr_d),
    .stall_e(stall_e), .flush(flush), .ready_d(ready_d), .valid_e(valid_e),
    .ctrl_e(ctrl_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .imm_e(imm_e),
    .illegal_e(illegal_e)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Expected issue record; lanes not issued carry all-zero fields.
  function automatic exp_t mk(input logic [1:0] v, input logic [31:0] i1, input logic [31:0] i0,
                              input logic [11:0] c1, input logic [11:0] c0, input logic [1:0] ill);
    exp_t e;
    e.v   = v;
    e.c   = {v[1] ? c1 : 12'h0, v[0] ? c0 : 12'h0};
    e.rs  = {v[1] ? i1[25:21] : 5'd0, v[0] ? i0[25:21] : 5'd0};
    e.rt  = {v[1] ? i1[20:16] : 5'd0, v[0] ? i0[20:16] : 5'd0};
    e.rd  = {v[1] ? i1[15:11] : 5'd0, v[0] ? i0[15:11] : 5'd0};
    e.imm = {v[1] ? i1[15:0] : 16'd0, v[0] ? i0[15:0] : 16'd0};
    e.ill = ill & v;
    return e;
  endfunction

  // Apply one cycle of inputs just after a rising edge and check the combinational ready.
  task automatic drive(input logic rn, input logic v, input logic [31:0] i1, input logic [31:0] i0,
                       input logic st, input logic fl, input logic exp_rdy, input string name);
    @(posedge clk);
    #1;
    resetn      = rn;
    instr_valid = v;
    instr_d     = {i1, i0};
    stall_e     = st;
    flush       = fl;
    #2;
    check({"ready_", name}, 128'(ready_d), 128'(exp_rdy));
  endtask

  // Monitor: every non-empty issue must match the oldest expected record.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (valid_e != 2'b00) begin
        a = {valid_e, ctrl_e, rs_e, rt_e, rd_e, imm_e, illegal_e};
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue act=%h exp=none", a);
        end else begin
          e = sb.pop_front();
          check("issue", 128'(a), 128'(e));
        end
      end
    end
  end

  localparam logic [31:0] LW8   = 32'h8D280000;  // lw   $8,0($9)
  localparam logic [31:0] ADD10 = 32'h016C5020;  // add  $10,$11,$12
  localparam logic [31:0] ADDI8 = 32'h20080005;  // addi $8,$0,5
  localparam logic [31:0] ADD9  = 32'h01084820;  // add  $9,$8,$8
  localparam logic [31:0] ADDI0 = 32'h20000005;  // addi $0,$0,5
  localparam logic [31:0] ADD8  = 32'h00004020;  // add  $8,$0,$0
  localparam logic [31:0] ADDIW = 32'h21280001;  // addi $8,$9,1
  localparam logic [31:0] ORI8  = 32'h35080001;  // ori  $8,$8,1
  localparam logic [31:0] BEQ8  = 32'h10080004;  // beq  $0,$8,4
  localparam logic [31:0] JMP   = 32'h08000010;  // j
  localparam logic [31:0] SW8   = 32'hAD280004;  // sw   $8,4($9)
  localparam logic [31:0] ILL   = 32'hFC090000;  // opcode 111111, rt field 9
  localparam logic [31:0] ANDI  = 32'h3128000F;  // andi $8,$9,15
  localparam logic [31:0] SLTIU = 32'h2D4A0003;  // sltiu $10,$10,3
  localparam logic [31:0] XORI  = 32'h39290001;  // xori $9,$9,1
  localparam logic [31:0] SLTI  = 32'h29AC0002;  // slti $12,$13,2
  localparam logic [31:0] ADDIU = 32'h25CE0007;  // addiu $14,$14,7
  localparam logic [31:0] BNE   = 32'h15E00003;  // bne  $15,$0,3

  initial begin
    resetn = 1'b0; instr_valid = 1'b0; instr_d = '0; stall_e = 1'b0; flush = 1'b0;

    // Reset holds ready low even with a bundle present, and clears all outputs.
    drive(0, 1, ADD10, LW8, 0, 0, 0, "rst0");
    drive(0, 1, ADD10, LW8, 0, 0, 0, "rst1");
    @(negedge clk);
    check("reset_valid", 128'(valid_e), 128'(0));
    check("reset_fields", 128'({ctrl_e, rs_e, rt_e, rd_e, imm_e, illegal_e}), 128'(0));

    drive(1, 1, ADD10, LW8, 0, 0, 1, "indep");
    sb.push_back(mk(2'b11, ADD10, LW8, 12'h848, 12'hC10, 2'b00));

    drive(1, 1, ADD9, ADDI8, 0, 0, 0, "raw_a");
    sb.push_back(mk(2'b01, ADD9, ADDI8, 12'h848, 12'h810, 2'b00));
    drive(1, 1, ADD9, ADDI8, 0, 0, 1, "raw_b");
    sb.push_back(mk(2'b10, ADD9, ADDI8, 12'h848, 12'h810, 2'b00));

    drive(1, 0, 32'h0, 32'h0, 0, 0, 0, "bubble");

    drive(1, 1, ADD8, ADDI0, 0, 0, 1, "zero_reg");
    sb.push_back(mk(2'b11, ADD8, ADDI0, 12'h848, 12'h810, 2'b00));

    drive(1, 1, ADDIW, ADDI8, 0, 0, 1, "rt_not_read");
    sb.push_back(mk(2'b11, ADDIW, ADDI8, 12'h810, 12'h810, 2'b00));

    drive(1, 1, ORI8, ADDI8, 0, 0, 0, "ori_a");
    sb.push_back(mk(2'b01, ORI8, ADDI8, 12'h870, 12'h810, 2'b00));
    drive(1, 1, ORI8, ADDI8, 0, 0, 1, "ori_b");
    sb.push_back(mk(2'b10, ORI8, ADDI8, 12'h870, 12'h810, 2'b00));

    drive(1, 1, BEQ8, LW8, 0, 0, 0, "beq_a");
    sb.push_back(mk(2'b01, BEQ8, LW8, 12'h024, 12'hC10, 2'b00));
    drive(1, 1, BEQ8, LW8, 0, 0, 1, "beq_b");
    sb.push_back(mk(2'b10, BEQ8, LW8, 12'h024, 12'hC10, 2'b00));

    drive(1, 1, SW8, JMP, 0, 0, 1, "j_sw");
    sb.push_back(mk(2'b11, SW8, JMP, 12'h210, 12'h001, 2'b00));

    drive(1, 1, SLTIU, ANDI, 0, 0, 1, "andi_sltiu");
    sb.push_back(mk(2'b11, SLTIU, ANDI, 12'h910, 12'h890, 2'b00));
    drive(1, 1, SLTI, XORI, 0, 0, 1, "xori_slti");
    sb.push_back(mk(2'b11, SLTI, XORI, 12'h8D0, 12'h8B0, 2'b00));
    drive(1, 1, BNE, ADDIU, 0, 0, 1, "addiu_bne");
    sb.push_back(mk(2'b11, BNE, ADDIU, 12'h022, 12'h8F0, 2'b00));

    drive(1, 1, LW8, ILL, 0, 0, 1, "illegal");
    sb.push_back(mk(2'b11, LW8, ILL, 12'hC10, 12'h000, 2'b01));

    // Stall in SPLIT then release: lane1 still issues afterwards.
    drive(1, 1, ADD9, ADDI8, 0, 0, 0, "stl_a");
    sb.push_back(mk(2'b01, ADD9, ADDI8, 12'h848, 12'h810, 2'b00));
    drive(1, 1, ADD9, ADDI8, 1, 0, 0, "stl_hold");
    sb.push_back(mk(2'b01, ADD9, ADDI8, 12'h848, 12'h810, 2'b00));
    drive(1, 1, ADD9, ADDI8, 0, 0, 1, "stl_b");
    sb.push_back(mk(2'b10, ADD9, ADDI8, 12'h848, 12'h810, 2'b00));

    // Stall three cycles in SPLIT, then flush with stall: lane1 is dropped.
    drive(1, 1, ADD9, ADDI8, 0, 0, 0, "fl_a");
    sb.push_back(mk(2'b01, ADD9, ADDI8, 12'h848, 12'h810, 2'b00));
    for (int n = 0; n < 3; n++) begin
      drive(1, 1, ADD9, ADDI8, 1, 0, 0, "fl_stall");
      sb.push_back(mk(2'b01, ADD9, ADDI8, 12'h848, 12'h810, 2'b00));
    end
    drive(1, 1, ADD9, ADDI8, 1, 1, 0, "flush");
    drive(1, 1, ADD10, LW8, 0, 0, 1, "after_flush");
    sb.push_back(mk(2'b11, ADD10, LW8, 12'h848, 12'hC10, 2'b00));

    // Reset in SPLIT abandons the held bundle.
    drive(1, 1, ADD9, ADDI8, 0, 0, 0, "rs_a");
    sb.push_back(mk(2'b01, ADD9, ADDI8, 12'h848, 12'h810, 2'b00));
    drive(0, 1, ADD9, ADDI8, 1, 1, 0, "rs_mid");
    drive(1, 1, ADD10, LW8, 0, 0, 1, "after_rst");
    sb.push_back(mk(2'b11, ADD10, LW8, 12'h848, 12'hC10, 2'b00));

    drive(1, 0, 32'h0, 32'h0, 0, 0, 0, "drain0");
    drive(1, 0, 32'h0, 32'h0, 0, 0, 0, "drain1");
    @(negedge clk);
    check("idle_valid", 128'(valid_e), 128'(0));
    check("sb_drained", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelinedec_ss.md
PIPELINEDEC_SS -- requirements
Module: pipelinedec_ss

Interface
REQ-001 Parameter LANES, default 2, instructions per decode bundle, legal range 1..4.
REQ-002 Parameter CW, default 12, control-bundle width per lane, fixed at 12.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 resetn  in  1  one clock; reset is synchronous and active-low.
REQ-005 instr_valid  in  1  instr_d holds a valid bundle.
REQ-006 instr_d  in  32*LANES  bundle; lane i at bits [32i+31:32i], lane 0 oldest.
REQ-007 stall_e  in  1  execute stage not accepting; hold all outputs.
REQ-008 flush  in  1  discard the bundle being decoded and all outputs.
REQ-009 ready_d  out  1  combinational; the current bundle is fully consumed at this edge.
REQ-010 valid_e  out  LANES  per-lane issued flag, registered.
REQ-011 ctrl_e  out  CW*LANES  per lane {regwrite,memtoreg,memwrite,aluop[3:0],alusrc,regdst,branch,bne,jump}, registered.
REQ-012 rs_e, rt_e, rd_e  out  5*LANES each  register fields per lane, registered.
REQ-013 imm_e  out  16*LANES  instr[15:0] per lane, registered.
REQ-014 illegal_e  out  LANES  opcode not in decode table, registered.

Function
REQ-015 Opcode table per lane, giving {regwrite,memtoreg,memwrite,aluop,alusrc,regdst,branch,bne,jump}:
- LW 100011 = 1,1,0,0000,1,0,0,0,0
- SW 101011 = 0,0,1,0000,1,0,0,0,0
- R-type 000000 = 1,0,0,0010,0,1,0,0,0
- BEQ 000100 = 0,0,0,0001,0,0,1,0,0
- BNE 000101 = 0,0,0,0001,0,0,0,1,0
- ADDI 001000 = 1,0,0,0000,1,0,0,0,0
- ADDIU 001001 = aluop 0111, ADDI otherwise
- ANDI 001100 = aluop 0100, ADDI otherwise
- ORI 001101 = aluop 0011, ADDI otherwise
- XORI 001110 = aluop 0101, ADDI otherwise
- SLTI 001010 = aluop 0110, ADDI otherwise
- SLTIU 001011 = aluop 1000, ADDI otherwise
- J 000010 = all 0 except jump=1
REQ-016 Any other opcode: ctrl all 0 and illegal=1; never X.
REQ-017 Lane destination: rd if regdst else rt, and only if regwrite=1.
- A lane reads rs always.
- A lane reads rt only for R-type, SW, BEQ, BNE.
REQ-018 Lane j depends on earlier lane i (ptr<=i<j) when:
- lane i's destination is nonzero, and
- it equals a register that lane j reads.
- Register $0 never creates a dependency.
REQ-019 FSM states:
- IDLE: ptr=0.
- SPLIT: ptr = first unissued lane of the held bundle.
REQ-020 Issue group: lanes ptr..k-1, where k is the lowest lane >ptr that depends on any lane in ptr..k-1; k=LANES if there is none.
REQ-021 Latency 1: a group issued at edge N appears at N+1.
- valid_e=1 only at the group's own lane positions; all other lanes show valid_e=0.
- Field values of invalid lanes are don't-care but shall be 0.
REQ-022 k<LANES: FSM to SPLIT with ptr=k; ready_d=0.
REQ-023 k=LANES: FSM to IDLE with ptr=0; ready_d=1.
REQ-024 ready_d = instr_valid & !stall_e & !flush & (k==LANES).
REQ-025 instr_valid=0 and not stalled: valid_e<=0 (bubble); FSM unchanged.
REQ-026 stall_e=1 with flush=0: outputs, FSM and ptr all hold; ready_d=0.
REQ-027 flush=1 (priority over stall_e):
- valid_e<=0, FSM to IDLE, ptr<=0, ready_d=0.
- Remaining split lanes are dropped.
- Upstream flushes its own bundle in the same cycle.
REQ-028 Illegal lanes still issue with valid_e=1 and illegal_e=1; they create no dependency.
REQ-029 LANES=1: FSM never leaves IDLE; behaviour is a registered single decoder.

Reset
REQ-030 resetn=0 at an edge forces:
- valid_e=0, ctrl_e=0, rs_e/rt_e/rd_e/imm_e=0, illegal_e=0.
- FSM=IDLE, ptr=0.
REQ-031 Reset overrides flush and stall_e.
REQ-032 While resetn=0, ready_d=0.
REQ-033 Reset asserted during SPLIT abandons the held bundle.

Verification (LANES=2)
REQ-034 Reset: resetn=0 for 2 cycles -> valid_e=00, ctrl_e=0, ready_d=0.
REQ-035 Independent bundle: lane0 0x8D280000 (lw $8,0($9)), lane1 0x016C5020 (add $10,$11,$12) -> ready_d=1; next cycle valid_e=11, lane0 ctrl=110000010000, lane1 ctrl=100001001000.
REQ-036 RAW split: lane0 0x20080005 (addi $8,$0,5), lane1 0x01084820 (add $9,$8,$8):
- cycle 1: valid_e=01, ready_d=0.
- cycle 2: valid_e=10, ready_d=1.
- cycle 3: next bundle.
REQ-037 $0 and non-read rt: lane0 0x20000005 (addi $0), lane1 0x00004020 (add $8,$0,$0) -> no split, valid_e=11.
- Repeat with lane0 writing $8 and lane1 0x35080001 (ori $8,$8,1) -> split, because rs matches.
REQ-038 Stall and flush in SPLIT:
- stall_e=1 for 3 cycles -> valid_e=01 held, ptr=1 held.
- Then flush=1 with stall_e=1 -> next valid_e=00, FSM IDLE, lane1 never issued.
REQ-039 Illegal: lane0 opcode 111111 -> valid_e[0]=1, illegal_e[0]=1, ctrl lane0=0, lane1 issues in the same cycle.
